// File: rtl/jtag_tap_multi_dr.sv
// IEEE 1149.1-style TAP controller with a parametrised IR, BYPASS, IDCODE and
// NUM_UDR user data registers exposing parallel capture/update ports to the core.
module jtag_tap_multi_dr #(
    parameter int          IR_WIDTH   = 5,
    parameter int          NUM_UDR    = 2,
    parameter int          UDR_WIDTH  = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                           TCK,
    input  logic                           TRST_N,
    input  logic                           TMS,
    input  logic                           TDI,
    output logic                           TDO,
    output logic                           TDO_EN,
    input  logic [NUM_UDR*UDR_WIDTH-1:0]   udr_cap_in,
    output logic [NUM_UDR*UDR_WIDTH-1:0]   udr_out,
    output logic [NUM_UDR-1:0]             udr_upd,
    output logic [3:0]                     tap_state,
    output logic [IR_WIDTH-1:0]            ir_out
);

    typedef enum logic [3:0] {
        TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
        SH_DR  = 4'h4, EX1_DR = 4'h5, PS_DR  = 4'h6, EX2_DR = 4'h7,
        UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
        EX1_IR = 4'hC, PS_IR  = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
    } tap_state_e;

    tap_state_e             state_q, state_d;
    logic [IR_WIDTH-1:0]    ir_sr;
    logic                   bypass_sr;
    logic [31:0]            id_sr;
    logic [UDR_WIDTH-1:0]   udr_sr [NUM_UDR];
    logic [NUM_UDR-1:0]     user_sel;
    logic                   sel_idcode;
    logic                   sel_bypass;
    logic                   user_bit;
    logic                   tdo_d;

    assign tap_state = state_q;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = TMS ? TLR    : RTI;
            RTI:     state_d = TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = TMS ? UPD_DR : PS_DR;
            PS_DR:   state_d = TMS ? EX2_DR : PS_DR;
            EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = TMS ? UPD_IR : PS_IR;
            PS_IR:   state_d = TMS ? EX2_IR : PS_IR;
            EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // All-ones wins over the USER range so a wide NUM_UDR can never shadow BYPASS
    always_comb begin
        user_sel = '0;
        for (int k = 0; k < NUM_UDR; k++)
            user_sel[k] = (int'(ir_out) == k + 2) && (ir_out != '1);
    end

    assign sel_idcode = (ir_out == IR_WIDTH'(1));
    assign sel_bypass = !sel_idcode && !(|user_sel);

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr <= '0;
        end else if (state_q == CAP_IR) begin
            ir_sr <= IR_WIDTH'(1);
        end else if (state_q == SH_IR) begin
            ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Entering TLR forces IDCODE even when arriving through UpdIR's successor path
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_out <= IR_WIDTH'(1);
        end else if (state_d == TLR) begin
            ir_out <= IR_WIDTH'(1);
        end else if (state_q == UPD_IR) begin
            ir_out <= ir_sr;
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass_sr <= 1'b0;
        end else if (sel_bypass) begin
            if (state_q == CAP_DR)     bypass_sr <= 1'b0;
            else if (state_q == SH_DR) bypass_sr <= TDI;
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            id_sr <= '0;
        end else if (sel_idcode) begin
            if (state_q == CAP_DR)     id_sr <= IDCODE_VAL;
            else if (state_q == SH_DR) id_sr <= {TDI, id_sr[31:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            for (int k = 0; k < NUM_UDR; k++) udr_sr[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_UDR; k++) begin
                if (user_sel[k]) begin
                    if (state_q == CAP_DR)
                        udr_sr[k] <= udr_cap_in[k*UDR_WIDTH +: UDR_WIDTH];
                    else if (state_q == SH_DR)
                        udr_sr[k] <= {TDI, udr_sr[k][UDR_WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            udr_out <= '0;
            udr_upd <= '0;
        end else begin
            udr_upd <= '0;
            for (int k = 0; k < NUM_UDR; k++) begin
                if (state_q == UPD_DR && user_sel[k]) begin
                    udr_out[k*UDR_WIDTH +: UDR_WIDTH] <= udr_sr[k];
                    udr_upd[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        user_bit = 1'b0;
        for (int k = 0; k < NUM_UDR; k++)
            if (user_sel[k]) user_bit = udr_sr[k][0];
        tdo_d = 1'b0;
        case (state_q)
            SH_IR: tdo_d = ir_sr[0];
            SH_DR: begin
                if (sel_idcode)     tdo_d = id_sr[0];
                else if (|user_sel) tdo_d = user_bit;
                else                tdo_d = bypass_sr;
            end
            default: tdo_d = 1'b0;
        endcase
    end

    // TDO changes on the falling edge so the far end samples it cleanly on the next rise
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= tdo_d;
            TDO_EN <= (state_q == SH_IR) || (state_q == SH_DR);
        end
    end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Bench for jtag_tap_multi_dr: directed scans plus random TMS/TDI walks checked
// against a table-driven TAP reference model.
module tb_jtag_tap_multi_dr;

    localparam int IRW = 5;
    localparam int NU  = 2;
    localparam int UW  = 8;
    localparam longint IDC = 64'h1000_0001;

    logic TCK = 1'b0, TRST_N = 1'b1, TMS = 1'b1, TDI = 1'b0;
    logic TDO, TDO_EN;
    logic [NU*UW-1:0] udr_cap_in = '0;
    logic [NU*UW-1:0] udr_out;
    logic [NU-1:0]    udr_upd;
    logic [3:0]       tap_state;
    logic [IRW-1:0]   ir_out;

    jtag_tap_multi_dr #(.IR_WIDTH(IRW), .NUM_UDR(NU), .UDR_WIDTH(UW), .IDCODE_VAL(32'h1000_0001)) dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .udr_cap_in(udr_cap_in), .udr_out(udr_out), .udr_upd(udr_upd),
        .tap_state(tap_state), .ir_out(ir_out)
    );

    always #5 TCK = ~TCK;

    int checks = 0;
    int failures = 0;
    logic last_tdo;

    // Standard 1149.1 transition table indexed by state number
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int path_bits [16] = '{0, 0, 2, 2, 2, 10, 10, 42, 26, 6, 6, 6, 22, 22, 86, 54};
    int path_len  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

    int     m_state, m_ir, m_irsr, m_upd;
    bit     m_byp;
    longint m_id;
    int     m_usr [NU];
    int     m_uout [NU];

    // -1 bypass, -2 idcode, k>=0 user register k
    function automatic int sel_kind(input int ir);
        if (ir == (1 << IRW) - 1) return -1;
        if (ir == 1) return -2;
        if (ir >= 2 && ir <= NU + 1) return ir - 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ir = 1; m_irsr = 0; m_upd = 0; m_byp = 0; m_id = 0;
        for (int k = 0; k < NU; k++) begin m_usr[k] = 0; m_uout[k] = 0; end
    endtask

    task automatic model_rise(input bit tms, input bit tdi);
        int s = m_state;
        int k = sel_kind(m_ir);
        int ns;
        m_upd = 0;
        if (s == 10) m_irsr = 1;
        if (s == 11) m_irsr = (m_irsr >> 1) | (int'(tdi) << (IRW - 1));
        if (s == 3) begin
            if (k == -1) m_byp = 0;
            else if (k == -2) m_id = IDC;
            else m_usr[k] = int'((udr_cap_in >> (k * UW)) & ((1 << UW) - 1));
        end
        if (s == 4) begin
            if (k == -1) m_byp = tdi;
            else if (k == -2) m_id = (m_id >> 1) | (longint'(tdi) << 31);
            else m_usr[k] = (m_usr[k] >> 1) | (int'(tdi) << (UW - 1));
        end
        if (s == 8 && k >= 0) begin
            m_uout[k] = m_usr[k];
            m_upd = 1 << k;
        end
        ns = tms ? nxt1[s] : nxt0[s];
        if (ns == 0) m_ir = 1;
        else if (s == 15) m_ir = m_irsr;
        m_state = ns;
    endtask

    function automatic int exp_tdo();
        int k = sel_kind(m_ir);
        if (m_state == 11) return m_irsr & 1;
        if (m_state == 4) begin
            if (k == -1) return int'(m_byp);
            if (k == -2) return int'(m_id & 1);
            return m_usr[k] & 1;
        end
        return 0;
    endfunction

    function automatic longint exp_uout();
        longint v = 0;
        for (int k = 0; k < NU; k++) v |= longint'(m_uout[k]) << (k * UW);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":state"},   64'(tap_state), 64'(m_state));
        chk({tag, ":ir_out"},  64'(ir_out),    64'(m_ir));
        chk({tag, ":tdo"},     64'(TDO),       64'(exp_tdo()));
        chk({tag, ":tdo_en"},  64'(TDO_EN),    64'((m_state == 4 || m_state == 11) ? 1 : 0));
        chk({tag, ":udr_out"}, 64'(udr_out),   64'(exp_uout()));
        chk({tag, ":udr_upd"}, 64'(udr_upd),   64'(m_upd));
    endtask

    task automatic step(input bit tms, input bit tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        model_rise(tms, tdi);
        @(negedge TCK);
        #1;
        last_tdo = TDO;
        check_all("step");
    endtask

    task automatic do_reset();
        TRST_N = 1'b0;
        #1;
        model_reset();
        check_all("trst");
        #1;
        TRST_N = 1'b1;
    endtask

    // Assumes current state is Shift-IR/DR; TDO observed before each shifting rise
    task automatic shift_n(input int n, input longint data, input bit exit_last, output longint cap);
        cap = 0;
        for (int i = 0; i < n; i++) begin
            cap |= longint'(last_tdo) << i;
            step((i == n - 1) && exit_last, data[i]);
        end
    endtask

    task automatic load_ir(input int val, output longint cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift_n(IRW, longint'(val), 1'b1, cap);
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_scan(input int n, input longint data, output longint cap);
        step(1, 0); step(0, 0); step(0, 0);
        shift_n(n, data, 1'b1, cap);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        longint cap, d;
        @(negedge TCK); #1;
        do_reset();
        step(0, 0);

        // IDCODE read after reset
        dr_scan(32, 0, cap);
        chk("t1_idcode", 64'(cap), 64'h1000_0001);

        // BYPASS: one-TCK delay
        load_ir(31, cap);
        dr_scan(8, 64'hA5, cap);
        chk("t2_bypass", 64'(cap), 64'h4A);

        // IR capture pattern and USER0 update, USER1 preloaded so it can be seen unchanged
        load_ir(3, cap);
        dr_scan(8, 64'hC3, cap);
        load_ir(2, cap);
        chk("t3_ircap", 64'(cap), 64'h01);
        dr_scan(8, 64'h3C, cap);
        chk("t3_udr_out", 64'(udr_out), 64'hC33C);

        // USER1 capture
        udr_cap_in = 16'h5A00 | 16'($urandom_range(0, 255));
        load_ir(3, cap);
        dr_scan(8, 64'($urandom_range(0, 255)), cap);
        chk("t4_capture", 64'(cap), 64'h5A);

        // Five TMS=1 from every state returns to TLR with IDCODE
        step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < path_len[s]; i++) step(path_bits[s][i], 1'($urandom_range(0, 1)));
            chk("t5_reach", 64'(tap_state), 64'(s));
            for (int i = 0; i < 5; i++) step(1, 1'($urandom_range(0, 1)));
            chk("t5_tlr_state", 64'(tap_state), 64'h0);
            chk("t5_tlr_ir", 64'(ir_out), 64'h1);
        end
        step(0, 0);
        load_ir(10, cap);
        d = longint'($urandom_range(0, 255));
        dr_scan(8, d, cap);
        chk("t5_undef_bypass", 64'(cap), 64'((d << 1) & 64'hFF));

        // Pause/resume without recapture, then abort by TRST_N mid-shift
        load_ir(2, cap);
        step(1, 0); step(0, 0); step(0, 0);
        shift_n(4, 64'hB, 1'b1, cap);
        step(0, 0); step(1, 0); step(0, 0);
        shift_n(4, 64'h6, 1'b1, cap);
        step(1, 0); step(0, 0);
        chk("t6_pause_udr", 64'(udr_out[7:0]), 64'h6B);
        load_ir(2, cap);
        step(1, 0); step(0, 0); step(0, 0);
        shift_n(3, 64'h5, 1'b0, cap);
        do_reset();
        chk("t6_abort_udr", 64'(udr_out), 64'h0);
        chk("t6_abort_upd", 64'(udr_upd), 64'h0);
        step(0, 0);
        step(0, 0);

        // Random directed scans with random instructions and lengths
        for (int it = 0; it < 24; it++) begin
            udr_cap_in = 16'($urandom);
            load_ir(int'($urandom_range(0, 31)), cap);
            d = {32'($urandom), 32'($urandom)};
            dr_scan(int'($urandom_range(1, 40)), d, cap);
        end

        // Random walk with occasional asynchronous reset
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 15) == 0) udr_cap_in = 16'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            step(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
